// File: rtl/uiq_pkg.sv
// Unified issue queue shared definitions.
// Holds sizing defaults, opcode constants, FU class and decode helper.
package uiq_pkg;

  localparam int DEF_RS_SIZE  = 16;
  localparam int DEF_AR_SIZE  = 7;
  localparam int DEF_AR_ARRAY = 128;
  localparam int DEF_FU_SIZE  = 2;
  localparam int DEF_FU_ARRAY = 3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {
    FU_CLASS_ALU = 1'b0,
    FU_CLASS_LSU = 1'b1
  } fu_class_e;

  typedef struct packed {
    fu_class_e fu_class;
    logic      use_rs1;
    logic      use_rs2;
  } dec_t;

  function automatic dec_t decode(
    input logic [6:0] opcode
  );
    dec_t d;
    d.fu_class = FU_CLASS_ALU;
    d.use_rs1  = 1'b1;
    d.use_rs2  = 1'b1;
    unique case (1'b1)
      opcode == OP_LOAD: begin
        d.fu_class = FU_CLASS_LSU;
        d.use_rs2  = 1'b0;
      end
      opcode == OP_STORE: begin
        d.fu_class = FU_CLASS_LSU;
      end
      opcode == OP_IMM,
      opcode == OP_JALR: begin
        d.use_rs2 = 1'b0;
      end
      opcode == OP_LUI,
      opcode == OP_AUIPC,
      opcode == OP_JAL: begin
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uiq_select.sv
// Lowest-index priority picker for FU0/FU1 (ALU) and FU2 (LSU).
// In: per-entry eligibility, fu_ready; out: grant valid + index per port.
module uiq_select #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  alu_elig,
  input  logic [N-1:0]  lsu_elig,
  input  logic [2:0]    fu_ready,
  output logic [2:0]    gnt_vld,
  output logic [IW-1:0] gnt_idx0,
  output logic [IW-1:0] gnt_idx1,
  output logic [IW-1:0] gnt_idx2
);

  logic          a0_v;
  logic          a1_v;
  logic          l_v;
  logic [IW-1:0] a0;
  logic [IW-1:0] a1;
  logic [IW-1:0] l0;

  always_comb begin
    a0_v = 1'b0;
    a1_v = 1'b0;
    l_v  = 1'b0;
    a0   = '0;
    a1   = '0;
    l0   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (alu_elig[i]) begin
        a0_v = 1'b1;
        a0   = IW'(i);
      end
      if (lsu_elig[i]) begin
        l_v = 1'b1;
        l0  = IW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (alu_elig[i] && (IW'(i) != a0)) begin
        a1_v = 1'b1;
        a1   = IW'(i);
      end
    end
  end

  // FU1 takes the runner-up only when FU0 actually claims the winner.
  always_comb begin
    gnt_vld    = '0;
    gnt_vld[0] = fu_ready[0] && a0_v;
    gnt_idx0   = a0;
    if (fu_ready[0]) begin
      gnt_vld[1] = fu_ready[1] && a1_v;
      gnt_idx1   = a1;
    end else begin
      gnt_vld[1] = fu_ready[1] && a0_v;
      gnt_idx1   = a0;
    end
    gnt_vld[2] = fu_ready[2] && l_v;
    gnt_idx2   = l0;
  end

endmodule

// File: rtl/unified_issue_queue.sv
// Unified reservation-station issue queue with three registered ports.
// In: dispatch fields, ROB ready vectors, FU ready, result broadcast.
// Out: per-port rs1/rs2/rd/values/imm/fu_number, tunnel, no_issue, stall.
module unified_issue_queue
  import uiq_pkg::*;
#(
  parameter int RS_SIZE  = DEF_RS_SIZE,
  parameter int AR_SIZE  = DEF_AR_SIZE,
  parameter int AR_ARRAY = DEF_AR_ARRAY,
  parameter int FU_SIZE  = DEF_FU_SIZE,
  parameter int FU_ARRAY = DEF_FU_ARRAY
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [6:0]          opcode_in,
  input  logic [2:0]          funct3_in,
  input  logic [6:0]          funct7_in,
  input  logic [AR_SIZE-1:0]  rs1_in,
  input  logic [AR_SIZE-1:0]  rs2_in,
  input  logic [AR_SIZE-1:0]  rd_in,
  input  logic [31:0]         imm_value_in,
  input  logic [31:0]         rs1_value_in,
  input  logic [31:0]         rs2_value_in,
  input  logic [AR_ARRAY:0]   rs1_ready_from_ROB_in,
  input  logic [AR_ARRAY:0]   rs2_ready_from_ROB_in,
  input  logic [FU_ARRAY-1:0] fu_ready_from_FU_in,
  input  logic [AR_SIZE-1:0]  reg_tag_from_FU_in,
  input  logic [31:0]         reg_value_from_FU_in,
  output logic [AR_SIZE-1:0]  rs1_out0,
  output logic [AR_SIZE-1:0]  rs2_out0,
  output logic [AR_SIZE-1:0]  rd_out0,
  output logic [31:0]         rs1_value_out0,
  output logic [31:0]         rs2_value_out0,
  output logic [31:0]         imm_value_out0,
  output logic [FU_SIZE-1:0]  fu_number_out0,
  output logic [AR_SIZE-1:0]  rs1_out1,
  output logic [AR_SIZE-1:0]  rs2_out1,
  output logic [AR_SIZE-1:0]  rd_out1,
  output logic [31:0]         rs1_value_out1,
  output logic [31:0]         rs2_value_out1,
  output logic [31:0]         imm_value_out1,
  output logic [FU_SIZE-1:0]  fu_number_out1,
  output logic [AR_SIZE-1:0]  rs1_out2,
  output logic [AR_SIZE-1:0]  rs2_out2,
  output logic [AR_SIZE-1:0]  rd_out2,
  output logic [31:0]         rs1_value_out2,
  output logic [31:0]         rs2_value_out2,
  output logic [31:0]         imm_value_out2,
  output logic [FU_SIZE-1:0]  fu_number_out2,
  output logic                no_issue_out,
  output logic                stall_out,
  output logic [2:0]          tunnel_out
);

  localparam int IW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] valid_q;
  logic [RS_SIZE-1:0] lsu_q;
  logic [RS_SIZE-1:0] rdy1_q;
  logic [RS_SIZE-1:0] rdy2_q;
  logic [AR_SIZE-1:0] rs1_q  [RS_SIZE];
  logic [AR_SIZE-1:0] rs2_q  [RS_SIZE];
  logic [AR_SIZE-1:0] rd_q   [RS_SIZE];
  logic [31:0]        val1_q [RS_SIZE];
  logic [31:0]        val2_q [RS_SIZE];
  logic [31:0]        imm_q  [RS_SIZE];

  logic [AR_SIZE-1:0] o_rs1 [3];
  logic [AR_SIZE-1:0] o_rs2 [3];
  logic [AR_SIZE-1:0] o_rd  [3];
  logic [31:0]        o_v1  [3];
  logic [31:0]        o_v2  [3];
  logic [31:0]        o_imm [3];
  logic [2:0]         tunnel_q;

  dec_t               dec;
  logic               bc_vld;
  logic               s1_bc;
  logic               s2_bc;
  logic               s1_rdy;
  logic               s2_rdy;
  logic               dispatch;
  logic               free_vld;
  logic [IW-1:0]      free_idx;
  logic [RS_SIZE-1:0] disp_mask;
  logic [RS_SIZE-1:0] issue_mask;
  logic [RS_SIZE-1:0] elig;
  logic [2:0]         gnt_vld;
  logic [IW-1:0]      gnt_idx [3];
  logic               unused_funct;

  assign unused_funct = ^{funct3_in, funct7_in, free_vld};

  assign dec    = decode(opcode_in);
  assign bc_vld = reg_tag_from_FU_in != '0;

  // A same-cycle broadcast counts as ready and supplies the value.
  assign s1_bc = dec.use_rs1 && bc_vld &&
                 (rs1_in == reg_tag_from_FU_in);
  assign s2_bc = dec.use_rs2 && bc_vld &&
                 (rs2_in == reg_tag_from_FU_in);

  assign s1_rdy = !dec.use_rs1 || (rs1_in == '0) ||
                  rs1_ready_from_ROB_in[rs1_in] || s1_bc;
  assign s2_rdy = !dec.use_rs2 || (rs2_in == '0) ||
                  rs2_ready_from_ROB_in[rs2_in] || s2_bc;

  assign stall_out = &valid_q;
  assign dispatch  = (opcode_in != '0) && !stall_out;

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    disp_mask = '0;
    if (dispatch) disp_mask[free_idx] = 1'b1;
  end

  assign elig = valid_q & rdy1_q & rdy2_q;

  uiq_select #(
    .N  (RS_SIZE),
    .IW (IW)
  ) u_sel (
    .alu_elig (elig & ~lsu_q),
    .lsu_elig (elig & lsu_q),
    .fu_ready (fu_ready_from_FU_in[2:0]),
    .gnt_vld  (gnt_vld),
    .gnt_idx0 (gnt_idx[0]),
    .gnt_idx1 (gnt_idx[1]),
    .gnt_idx2 (gnt_idx[2])
  );

  always_comb begin
    issue_mask = '0;
    for (int k = 0; k < 3; k++) begin
      if (gnt_vld[k]) issue_mask[gnt_idx[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q  <= '0;
      tunnel_q <= '0;
      for (int k = 0; k < 3; k++) begin
        o_rs1[k] <= '0;
        o_rs2[k] <= '0;
        o_rd[k]  <= '0;
        o_v1[k]  <= '0;
        o_v2[k]  <= '0;
        o_imm[k] <= '0;
      end
    end else begin
      valid_q  <= (valid_q & ~issue_mask) | disp_mask;
      tunnel_q <= gnt_vld;
      for (int k = 0; k < 3; k++) begin
        if (gnt_vld[k]) begin
          o_rs1[k] <= rs1_q[gnt_idx[k]];
          o_rs2[k] <= rs2_q[gnt_idx[k]];
          o_rd[k]  <= rd_q[gnt_idx[k]];
          o_v1[k]  <= val1_q[gnt_idx[k]];
          o_v2[k]  <= val2_q[gnt_idx[k]];
          o_imm[k] <= imm_q[gnt_idx[k]];
        end else begin
          o_rs1[k] <= '0;
          o_rs2[k] <= '0;
          o_rd[k]  <= '0;
          o_v1[k]  <= '0;
          o_v2[k]  <= '0;
          o_imm[k] <= '0;
        end
      end
    end
  end

  // Payload writes during reset are harmless: valid stays clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (disp_mask[i]) begin
        lsu_q[i]  <= dec.fu_class == FU_CLASS_LSU;
        rs1_q[i]  <= rs1_in;
        rs2_q[i]  <= rs2_in;
        rd_q[i]   <= rd_in;
        imm_q[i]  <= imm_value_in;
        rdy1_q[i] <= s1_rdy;
        rdy2_q[i] <= s2_rdy;
        val1_q[i] <= s1_bc ? reg_value_from_FU_in : rs1_value_in;
        val2_q[i] <= s2_bc ? reg_value_from_FU_in : rs2_value_in;
      end else if (valid_q[i] && bc_vld) begin
        if (!rdy1_q[i] && (rs1_q[i] == reg_tag_from_FU_in)) begin
          rdy1_q[i] <= 1'b1;
          val1_q[i] <= reg_value_from_FU_in;
        end
        if (!rdy2_q[i] && (rs2_q[i] == reg_tag_from_FU_in)) begin
          rdy2_q[i] <= 1'b1;
          val2_q[i] <= reg_value_from_FU_in;
        end
      end
    end
  end

  assign tunnel_out   = tunnel_q;
  assign no_issue_out = tunnel_q == 3'b000;

  assign rs1_out0       = o_rs1[0];
  assign rs2_out0       = o_rs2[0];
  assign rd_out0        = o_rd[0];
  assign rs1_value_out0 = o_v1[0];
  assign rs2_value_out0 = o_v2[0];
  assign imm_value_out0 = o_imm[0];
  assign fu_number_out0 = '0;

  assign rs1_out1       = o_rs1[1];
  assign rs2_out1       = o_rs2[1];
  assign rd_out1        = o_rd[1];
  assign rs1_value_out1 = o_v1[1];
  assign rs2_value_out1 = o_v2[1];
  assign imm_value_out1 = o_imm[1];
  assign fu_number_out1 = tunnel_q[1] ? FU_SIZE'(1) : '0;

  assign rs1_out2       = o_rs1[2];
  assign rs2_out2       = o_rs2[2];
  assign rd_out2        = o_rd[2];
  assign rs1_value_out2 = o_v1[2];
  assign rs2_value_out2 = o_v2[2];
  assign imm_value_out2 = o_imm[2];
  assign fu_number_out2 = tunnel_q[2] ? FU_SIZE'(2) : '0;

endmodule

// File: tb/tb_unified_issue_queue.sv
// Directed self-checking bench for unified_issue_queue.
// Walks dispatch, wakeup, select, LSU routing, reset and full-queue cases.
module tb_unified_issue_queue;

  logic         clk = 1'b0;
  logic         rstn;
  logic [6:0]   opcode_in;
  logic [2:0]   funct3_in;
  logic [6:0]   funct7_in;
  logic [6:0]   rs1_in, rs2_in, rd_in;
  logic [31:0]  imm_value_in, rs1_value_in, rs2_value_in;
  logic [128:0] rob1, rob2;
  logic [2:0]   fu_ready;
  logic [6:0]   bc_tag;
  logic [31:0]  bc_val;
  logic [6:0]   rs1_out0, rs2_out0, rd_out0;
  logic [6:0]   rs1_out1, rs2_out1, rd_out1;
  logic [6:0]   rs1_out2, rs2_out2, rd_out2;
  logic [31:0]  rs1_value_out0, rs2_value_out0, imm_value_out0;
  logic [31:0]  rs1_value_out1, rs2_value_out1, imm_value_out1;
  logic [31:0]  rs1_value_out2, rs2_value_out2, imm_value_out2;
  logic [1:0]   fu_number_out0, fu_number_out1, fu_number_out2;
  logic         no_issue_out, stall_out;
  logic [2:0]   tunnel_out;

  int errors = 0;
  int checks = 0;

  localparam logic [128:0] ALL_RDY = '1;

  unified_issue_queue dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .opcode_in             (opcode_in),
    .funct3_in             (funct3_in),
    .funct7_in             (funct7_in),
    .rs1_in                (rs1_in),
    .rs2_in                (rs2_in),
    .rd_in                 (rd_in),
    .imm_value_in          (imm_value_in),
    .rs1_value_in          (rs1_value_in),
    .rs2_value_in          (rs2_value_in),
    .rs1_ready_from_ROB_in (rob1),
    .rs2_ready_from_ROB_in (rob2),
    .fu_ready_from_FU_in   (fu_ready),
    .reg_tag_from_FU_in    (bc_tag),
    .reg_value_from_FU_in  (bc_val),
    .rs1_out0              (rs1_out0),
    .rs2_out0              (rs2_out0),
    .rd_out0               (rd_out0),
    .rs1_value_out0        (rs1_value_out0),
    .rs2_value_out0        (rs2_value_out0),
    .imm_value_out0        (imm_value_out0),
    .fu_number_out0        (fu_number_out0),
    .rs1_out1              (rs1_out1),
    .rs2_out1              (rs2_out1),
    .rd_out1               (rd_out1),
    .rs1_value_out1        (rs1_value_out1),
    .rs2_value_out1        (rs2_value_out1),
    .imm_value_out1        (imm_value_out1),
    .fu_number_out1        (fu_number_out1),
    .rs1_out2              (rs1_out2),
    .rs2_out2              (rs2_out2),
    .rd_out2               (rd_out2),
    .rs1_value_out2        (rs1_value_out2),
    .rs2_value_out2        (rs2_value_out2),
    .imm_value_out2        (imm_value_out2),
    .fu_number_out2        (fu_number_out2),
    .no_issue_out          (no_issue_out),
    .stall_out             (stall_out),
    .tunnel_out            (tunnel_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op,
                       input logic [6:0] r1,
                       input logic [6:0] r2,
                       input logic [6:0] rd,
                       input logic [31:0] imm,
                       input logic [31:0] v1,
                       input logic [31:0] v2);
    opcode_in    = op;
    rs1_in       = r1;
    rs2_in       = r2;
    rd_in        = rd;
    imm_value_in = imm;
    rs1_value_in = v1;
    rs2_value_in = v2;
  endtask

  task automatic nop();
    drive(7'd0, 7'd0, 7'd0, 7'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    int cnt;
    logic saw;
    rstn      = 1'b0;
    funct3_in = '0;
    funct7_in = '0;
    rob1      = ALL_RDY;
    rob2      = ALL_RDY;
    fu_ready  = 3'b111;
    bc_tag    = 7'd2;
    bc_val    = 32'd55;
    // Dispatch presented during reset must be dropped.
    drive(7'b0110011, 7'd1, 7'd2, 7'd3, 32'd0, 32'd1, 32'd2);
    tick();
    tick();
    chk("rst_tunnel", {29'd0, tunnel_out}, 32'd0);
    chk("rst_no_issue", {31'd0, no_issue_out}, 32'd1);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_rd_out0", {25'd0, rd_out0}, 32'd0);
    chk("rst_fu_num2", {30'd0, fu_number_out2}, 32'd0);
    rstn   = 1'b1;
    bc_tag = 7'd0;
    nop();
    tick();
    tick();
    chk("rst_ignored_disp", {29'd0, tunnel_out}, 32'd0);

    // add x4,x5,x2 with tag 2 not ready.
    rob2 = ALL_RDY & ~(129'd1 << 2);
    drive(7'b0110011, 7'd5, 7'd2, 7'd4, 32'd0, 32'd10, 32'd20);
    tick();
    chk("add_no_issue", {31'd0, no_issue_out}, 32'd1);
    // ori x4,x0,4.
    drive(7'b0010011, 7'd0, 7'd4, 7'd4, 32'd4, 32'd0, 32'd0);
    tick();
    chk("add_wait", {29'd0, tunnel_out}, 32'd0);
    nop();
    tick();
    chk("ori_tunnel", {29'd0, tunnel_out}, 32'd1);
    chk("ori_rd", {25'd0, rd_out0}, 32'd4);
    chk("ori_imm", imm_value_out0, 32'd4);
    chk("ori_fu_num", {30'd0, fu_number_out0}, 32'd0);
    chk("ori_no_issue", {31'd0, no_issue_out}, 32'd0);

    // Broadcast tag 2: wakeup edge does not issue.
    bc_tag = 7'd2;
    bc_val = 32'd1;
    tick();
    chk("wake_same_cycle", {29'd0, tunnel_out}, 32'd0);
    bc_tag = 7'd0;
    bc_val = 32'd0;
    tick();
    chk("add_tunnel", {29'd0, tunnel_out}, 32'd1);
    chk("add_rs2_val", rs2_value_out0, 32'd1);
    chk("add_rs1_val", rs1_value_out0, 32'd10);
    chk("add_rd", {25'd0, rd_out0}, 32'd4);
    chk("add_rs2_tag", {25'd0, rs2_out0}, 32'd2);
    tick();
    chk("idle_tunnel", {29'd0, tunnel_out}, 32'd0);
    chk("idle_rd_zero", {25'd0, rd_out0}, 32'd0);

    // lw x8,0(x5) on FU2.
    fu_ready = 3'b101;
    drive(7'b0000011, 7'd5, 7'd0, 7'd8, 32'd0, 32'h100, 32'd0);
    tick();
    chk("lw_wait", {29'd0, tunnel_out}, 32'd0);
    // add x6,x7,x3 made ready by same-cycle broadcast.
    rob2   = ALL_RDY & ~(129'd1 << 2) & ~(129'd1 << 3);
    bc_tag = 7'd3;
    bc_val = 32'd99;
    drive(7'b0110011, 7'd7, 7'd3, 7'd6, 32'd0, 32'd0, 32'd5);
    tick();
    chk("lw_tunnel", {29'd0, tunnel_out}, 32'd4);
    chk("lw_fu_num", {30'd0, fu_number_out2}, 32'd2);
    chk("lw_rd", {25'd0, rd_out2}, 32'd8);
    chk("lw_rs1_val", rs1_value_out2, 32'h100);
    bc_tag   = 7'd0;
    bc_val   = 32'd0;
    rob2     = ALL_RDY & ~(129'd1 << 2);
    fu_ready = 3'b010;
    nop();
    tick();
    chk("fu1_tunnel", {29'd0, tunnel_out}, 32'd2);
    chk("fu1_rd", {25'd0, rd_out1}, 32'd6);
    chk("fu1_bc_val", rs2_value_out1, 32'd99);
    chk("fu1_fu_num", {30'd0, fu_number_out1}, 32'd1);

    // Two ready ALU ops split across FU0 and FU1.
    fu_ready = 3'b000;
    drive(7'b0110011, 7'd1, 7'd1, 7'd9, 32'd0, 32'd0, 32'd0);
    tick();
    drive(7'b0110011, 7'd1, 7'd1, 7'd10, 32'd0, 32'd0, 32'd0);
    tick();
    nop();
    fu_ready = 3'b011;
    tick();
    chk("dual_tunnel", {29'd0, tunnel_out}, 32'd3);
    chk("dual_rd0", {25'd0, rd_out0}, 32'd9);
    chk("dual_rd1", {25'd0, rd_out1}, 32'd10);

    // Fill all 16 entries; tag 2 never ready.
    fu_ready = 3'b000;
    for (int i = 0; i < 16; i++) begin
      drive(7'b0110011, 7'd1, 7'd2, 7'(32 + i), 32'd0, 32'd0, 32'd0);
      tick();
      chk($sformatf("fill_stall_%0d", i), {31'd0, stall_out},
          (i == 15) ? 32'd1 : 32'd0);
    end
    drive(7'b0110011, 7'd1, 7'd1, 7'd100, 32'd0, 32'd0, 32'd0);
    tick();
    chk("full_stall", {31'd0, stall_out}, 32'd1);
    chk("full_tunnel", {29'd0, tunnel_out}, 32'd0);
    nop();
    bc_tag   = 7'd2;
    bc_val   = 32'd7;
    fu_ready = 3'b001;
    tick();
    chk("full_wake", {29'd0, tunnel_out}, 32'd0);
    bc_tag = 7'd0;
    bc_val = 32'd0;
    tick();
    chk("free_tunnel", {29'd0, tunnel_out}, 32'd1);
    chk("free_rd", {25'd0, rd_out0}, 32'd32);
    chk("free_val", rs2_value_out0, 32'd7);
    chk("free_stall", {31'd0, stall_out}, 32'd0);
    fu_ready = 3'b011;
    tick();
    chk("drain_rd0", {25'd0, rd_out0}, 32'd33);
    chk("drain_rd1", {25'd0, rd_out1}, 32'd34);
    cnt = 32'(tunnel_out[0]) + 32'(tunnel_out[1]);
    saw = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      cnt += 32'(tunnel_out[0]) + 32'(tunnel_out[1]);
      if (rd_out0 == 7'd100 || rd_out1 == 7'd100) saw = 1'b1;
    end
    chk("drain_count", cnt, 32'd15);
    chk("drain_no_17th", {31'd0, saw}, 32'd0);
    chk("drain_no_issue", {31'd0, no_issue_out}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unified_issue_queue.md
UNIFIED_ISSUE_QUEUE -- requirements
Module: unified_issue_queue

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: RS_SIZE 16, queue entries; AR_SIZE 7, tag width; AR_ARRAY 128, tag count; FU_SIZE 2, FU-number width; FU_ARRAY 3, number of FUs.
REQ-002 Ports (name direction width meaning) SHALL be: clk in 1 clock, the only clock; rstn in 1 reset, synchronous active-low.
REQ-003 opcode_in in 7, funct3_in in 3, funct7_in in 7: decoded fields of the dispatched instruction.
REQ-004 rs1_in, rs2_in, rd_in in AR_SIZE; imm_value_in in 32: source/destination tags and immediate.
REQ-005 rs1_value_in, rs2_value_in in 32: operand values read at dispatch.
REQ-006 rs1_ready_from_ROB_in, rs2_ready_from_ROB_in in AR_ARRAY+1: per-tag ready vectors, indexed by tag.
REQ-007 fu_ready_from_FU_in in FU_ARRAY: bit k = FU k can accept an instruction this cycle.
REQ-008 reg_tag_from_FU_in in AR_SIZE, reg_value_from_FU_in in 32: result broadcast; tag 0 = no broadcast.
REQ-009 For k=0..2: rs1_outk, rs2_outk, rd_outk out AR_SIZE; rs1_value_outk, rs2_value_outk, imm_value_outk out 32; fu_number_outk out FU_SIZE: issue port k.
REQ-010 no_issue_out out 1, nothing issued; stall_out out 1, queue full; tunnel_out out 3, bit k = port k valid.

Function
REQ-011 Dispatch: opcode_in != 0 and stall_out == 0 SHALL write the instruction into the lowest-index free entry at the rising edge; opcode 0 (nop) SHALL not dispatch.
REQ-012 FU class: opcodes 0000011 (load) and 0100011 (store) SHALL map to FU2; all other opcodes (R-type 0110011, I-ALU 0010011, LUI, AUIPC, branches) SHALL map to FU0/FU1.
REQ-013 Source readiness at dispatch: rsN_ready = rsN_ready_from_ROB_in[rsN_in] OR (rsN_in == reg_tag_from_FU_in and that tag is nonzero); tag 0 and unused sources (rs2 of I-type/load/LUI/AUIPC, rs1 of LUI/AUIPC) SHALL be ready.
REQ-014 Stored operand value SHALL be reg_value_from_FU_in when readiness comes from a same-cycle broadcast, else rsN_value_in.
REQ-015 Wakeup: each cycle, every valid entry whose pending source tag equals a nonzero reg_tag_from_FU_in SHALL set that source ready and latch reg_value_from_FU_in.
REQ-016 Eligibility: an entry is eligible when valid and both sources are ready at the start of the cycle; a dispatched entry is eligible no earlier than the cycle after dispatch.
REQ-017 Select: FU0 SHALL take the lowest-index eligible FU0/FU1-class entry if fu_ready[0]; FU1 SHALL take the next such entry if fu_ready[1]; FU2 SHALL take the lowest-index eligible load/store entry if fu_ready[2]; at most one entry per FU per cycle.
REQ-018 Issue ports SHALL be registered: at the edge, port k SHALL load the selected entry's rs1, rs2, rd, both values and imm; fu_number_outk SHALL equal k; tunnel_out[k]=1; that entry SHALL be freed the same edge.
REQ-019 A port with no issue SHALL drive all fields 0 and tunnel_out[k]=0; no_issue_out SHALL be 1 iff tunnel_out == 0.
REQ-020 stall_out SHALL be combinational: 1 when all RS_SIZE entries are valid; an entry freed by issue at an edge SHALL be reusable for a dispatch no earlier than the next edge.
REQ-021 Simultaneous wakeup and issue of the same tag SHALL be legal; the entry issues no earlier than the following cycle.

Reset
REQ-022 While rstn == 0 at a rising edge, all entries SHALL become invalid and all issue-port outputs, tunnel_out and fu_number_outk SHALL become 0; no_issue_out SHALL be 1 and stall_out 0.
REQ-023 Dispatch and broadcast inputs presented during reset SHALL be ignored.

Structure
REQ-024 A shared package uiq_pkg SHALL hold the sizing parameters, opcode constants and FU-class encoding.
REQ-025 Instruction decode SHALL remain in the existing decoder; one sub-module, uiq_select (lowest-index priority picker per FU), is natural.

Verification
REQ-026 Reset, then add x4,x5,x2 (0x00228233) with ready vectors 9'b111111011 (tag 2 not ready) -> dispatched, not issued, no_issue_out=1.
REQ-027 Next cycle ori x4,x0,4 (0x00406213), fu_ready 3'b111 -> cycle after: tunnel_out[0]=1, rd_out0=4, imm_value_out0=4, fu_number_out0=0.
REQ-028 Broadcast tag 2 value 1 -> next cycle add issues on FU0 with rs2_value_out0=1, rd_out0=4.
REQ-029 lw x8,0(x5) (0x0002a403) with fu_ready 3'b101 -> issues on port 2, fu_number_out2=2, rd_out2=8; with fu_ready 3'b010 a ready ALU op issues on port 1 only.
REQ-030 16 dispatches with tag 2 never ready and fu_ready 0 -> stall_out=1 and a 17th dispatch ignored; one issue frees an entry and stall_out=0.
